// File: rtl/f2c_dma_sched.sv
// F2C DMA sequencer: slices the source stream into MWr TLPs filling a host chunk ring and
// interleaves the metrics writeback; payload is a zero-latency pass-through stalled by txReady_in.
module f2c_dma_sched #(
  parameter int PTR_NBITS      = 2,
  parameter int TLP_NQWS       = 16,
  parameter int TLPS_PER_CHUNK = 4
) (
  input  logic                 clk_in,
  input  logic                 reset_in,
  input  logic [1:0]           dmaEnable_in,
  input  logic [28:0]          f2cBase_in,
  input  logic [28:0]          mtrBase_in,
  input  logic [PTR_NBITS-1:0] f2cRdPtr_in,
  input  logic [PTR_NBITS-1:0] c2fRdPtr_in,
  input  logic [63:0]          srcData_in,
  input  logic                 srcValid_in,
  output logic                 srcReady_out,
  output logic                 txReqValid_out,
  output logic [28:0]          txReqAddr_out,
  output logic [7:0]           txReqLen_out,
  input  logic                 txReqReady_in,
  output logic [63:0]          txData_out,
  output logic                 txValid_out,
  input  logic                 txReady_in,
  output logic [PTR_NBITS-1:0] f2cWrPtr_out,
  output logic                 busy_out
);

  localparam int QW_W = (TLP_NQWS > 1) ? $clog2(TLP_NQWS) : 1;
  localparam int TI_W = (TLPS_PER_CHUNK > 1) ? $clog2(TLPS_PER_CHUNK) : 1;
  localparam logic [28:0]     CHUNK_QWS = 29'(TLPS_PER_CHUNK * TLP_NQWS);
  localparam logic [28:0]     TLP_QWS   = 29'(TLP_NQWS);
  localparam logic [QW_W-1:0] QW_LAST   = QW_W'(TLP_NQWS - 1);
  localparam logic [TI_W-1:0] TI_LAST   = TI_W'(TLPS_PER_CHUNK - 1);

  typedef enum logic [2:0] {S_IDLE, S_HDR, S_DATA, S_MHDR, S_MDATA} state_e;

  state_e               state_q, state_d;
  logic [PTR_NBITS-1:0] wr_ptr_q, wr_ptr_d;
  logic [TI_W-1:0]      tlp_idx_q, tlp_idx_d;
  logic [QW_W-1:0]      qw_idx_q, qw_idx_d;
  logic                 mtr_pending_q, mtr_pending_d;
  logic [PTR_NBITS-1:0] last_c2f_q, last_c2f_d;

  logic                 soft_rst;
  logic                 run;
  logic                 full;
  logic                 mtr_set;
  logic                 mtr_clr;
  logic [PTR_NBITS-1:0] wr_ptr_inc;

  assign soft_rst     = reset_in || (dmaEnable_in == 2'd1);
  assign run          = (dmaEnable_in == 2'd2);
  assign wr_ptr_inc   = wr_ptr_q + PTR_NBITS'(1);
  // One slot stays empty so the host can tell a full ring from an empty one.
  assign full         = (wr_ptr_inc == f2cRdPtr_in);
  assign f2cWrPtr_out = wr_ptr_q;
  assign busy_out     = (state_q != S_IDLE);

  always_ff @(posedge clk_in) begin
    if (soft_rst) begin
      state_q       <= S_IDLE;
      wr_ptr_q      <= '0;
      tlp_idx_q     <= '0;
      qw_idx_q      <= '0;
      mtr_pending_q <= 1'b0;
      last_c2f_q    <= c2fRdPtr_in;
    end else begin
      state_q       <= state_d;
      wr_ptr_q      <= wr_ptr_d;
      tlp_idx_q     <= tlp_idx_d;
      qw_idx_q      <= qw_idx_d;
      mtr_pending_q <= mtr_pending_d;
      last_c2f_q    <= last_c2f_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    wr_ptr_d       = wr_ptr_q;
    tlp_idx_d      = tlp_idx_q;
    qw_idx_d       = qw_idx_q;
    last_c2f_d     = c2fRdPtr_in;
    mtr_set        = (c2fRdPtr_in != last_c2f_q);
    mtr_clr        = 1'b0;
    srcReady_out   = 1'b0;
    txReqValid_out = 1'b0;
    txReqAddr_out  = '0;
    txReqLen_out   = '0;
    txData_out     = '0;
    txValid_out    = 1'b0;

    case (state_q)
      // Arbitration happens only here, so a started TLP always runs to completion.
      S_IDLE: begin
        if (run) begin
          if (mtr_pending_q)
            state_d = S_MHDR;
          else if (!(tlp_idx_q == '0 && full) && srcValid_in)
            state_d = S_HDR;
        end
      end
      S_HDR: begin
        txReqValid_out = 1'b1;
        txReqAddr_out  = f2cBase_in + 29'(wr_ptr_q) * CHUNK_QWS + 29'(tlp_idx_q) * TLP_QWS;
        txReqLen_out   = 8'(TLP_NQWS);
        if (txReqReady_in) begin
          state_d  = S_DATA;
          qw_idx_d = '0;
        end
      end
      S_DATA: begin
        txData_out   = srcData_in;
        txValid_out  = srcValid_in;
        srcReady_out = txReady_in;
        if (srcValid_in && txReady_in) begin
          qw_idx_d = qw_idx_q + QW_W'(1);
          if (qw_idx_q == QW_LAST) begin
            state_d = S_IDLE;
            if (tlp_idx_q == TI_LAST) begin
              tlp_idx_d = '0;
              wr_ptr_d  = wr_ptr_inc;
              mtr_set   = 1'b1;
            end else begin
              tlp_idx_d = tlp_idx_q + TI_W'(1);
            end
          end
        end
      end
      S_MHDR: begin
        txReqValid_out = 1'b1;
        txReqAddr_out  = mtrBase_in;
        txReqLen_out   = 8'd1;
        if (txReqReady_in)
          state_d = S_MDATA;
      end
      S_MDATA: begin
        // Low dword lands at MTR_BASE+0 (F2C write ptr), high dword at MTR_BASE+4 (C2F read ptr).
        txValid_out = 1'b1;
        txData_out  = {32'(last_c2f_q), 32'(wr_ptr_q)};
        if (txReady_in) begin
          mtr_clr = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    mtr_pending_d = mtr_set ? 1'b1 : (mtr_clr ? 1'b0 : mtr_pending_q);
  end

endmodule

// File: tb/tb_f2c_dma_sched.sv
// Randomised bench for f2c_dma_sched: a transaction-level scoreboard predicts headers,
// payload order, metrics contents and IDLE arbitration outcomes from the ring rules.
module tb_f2c_dma_sched;
  localparam int NQ     = 16;
  localparam int M_NONE = 0;
  localparam int M_DATA = 1;
  localparam int M_MTR  = 2;

  logic        clk = 1'b0;
  logic        reset_in;
  logic [1:0]  dma_en;
  logic [28:0] f2c_base, mtr_base;
  logic [1:0]  f2c_rdptr, c2f_rdptr;
  logic [63:0] src_data;
  logic        src_valid, srcReady_out;
  logic        txReqValid_out, txReqReady_in;
  logic [28:0] txReqAddr_out;
  logic [7:0]  txReqLen_out;
  logic [63:0] txData_out;
  logic        txValid_out, txReady_in;
  logic [1:0]  f2cWrPtr_out;
  logic        busy_out;

  always #5 clk = ~clk;

  f2c_dma_sched dut (
    .clk_in(clk), .reset_in(reset_in), .dmaEnable_in(dma_en),
    .f2cBase_in(f2c_base), .mtrBase_in(mtr_base),
    .f2cRdPtr_in(f2c_rdptr), .c2fRdPtr_in(c2f_rdptr),
    .srcData_in(src_data), .srcValid_in(src_valid), .srcReady_out(srcReady_out),
    .txReqValid_out(txReqValid_out), .txReqAddr_out(txReqAddr_out),
    .txReqLen_out(txReqLen_out), .txReqReady_in(txReqReady_in),
    .txData_out(txData_out), .txValid_out(txValid_out), .txReady_in(txReady_in),
    .f2cWrPtr_out(f2cWrPtr_out), .busy_out(busy_out)
  );

  int n_vec = 0;
  int n_err = 0;

  // Reference model state (transaction level)
  logic [63:0] src_mem [256];
  int          src_idx = 0;
  int          chunk = 0, tlp = 0, beats = 0, mode = M_NONE;
  int          n_dhdr = 0, n_mbeats = 0, n_tlps = 0;
  logic        owed = 1'b0, owed_dec = 1'b0, srcv_dec = 1'b0, busy_prev = 1'b1;
  logic [1:0]  en_dec = 2'd0, rdptr_dec = 2'd0, prev_c2f = 2'd0;
  logic [63:0] last_mpay = '0;
  logic [28:0] last_daddr = '0;
  logic [28:0] hdr_log [16];
  logic        rnd_rdy = 1'b0, rnd_src = 1'b0, rnd_misc = 1'b0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic is_full(input int c, input logic [1:0] rd);
    return 2'((c + 1) % 4) == rd;
  endfunction

  task automatic monitor();
    logic        exp_go, exp_mtr, set_f, clr_f;
    logic [28:0] ea;
    if (reset_in || dma_en == 2'd1) begin
      chunk = 0; tlp = 0; beats = 0; mode = M_NONE;
      owed = 1'b0; prev_c2f = c2f_rdptr; busy_prev = 1'b1;
    end else begin
      chk("wrptr", 64'(f2cWrPtr_out), 64'(chunk % 4));
      if (!busy_prev) begin
        exp_mtr = (en_dec == 2'd2) && owed_dec;
        exp_go  = exp_mtr || ((en_dec == 2'd2) && srcv_dec && !(tlp == 0 && is_full(chunk, rdptr_dec)));
        chk("idle_exit", 64'(busy_out), 64'(exp_go));
        if (busy_out) begin
          chk("hdr_vld", 64'(txReqValid_out), 64'd1);
          chk("hdr_kind", 64'(txReqLen_out), 64'(exp_mtr ? 1 : NQ));
        end
      end
      set_f = (c2f_rdptr != prev_c2f);
      clr_f = 1'b0;
      case (mode)
        M_NONE: begin
          chk("idle_srdy", 64'(srcReady_out), 64'd0);
          chk("idle_txv", 64'(txValid_out), 64'd0);
          if (txReqValid_out && txReqReady_in) begin
            if (txReqLen_out == 8'd1) begin
              chk("mhdr_addr", 64'(txReqAddr_out), 64'(mtr_base));
              mode = M_MTR;
            end else begin
              ea = f2c_base + 29'((chunk % 4) * 64 + tlp * 16);
              chk("dhdr_len", 64'(txReqLen_out), 64'(NQ));
              chk("dhdr_addr", 64'(txReqAddr_out), 64'(ea));
              if (n_dhdr < 16) hdr_log[n_dhdr] = txReqAddr_out;
              last_daddr = txReqAddr_out;
              n_dhdr++;
              beats = 0;
              mode = M_DATA;
            end
          end
        end
        M_DATA: begin
          chk("data_txv", 64'(txValid_out), 64'(src_valid));
          chk("data_srdy", 64'(srcReady_out), 64'(txReady_in));
          chk("data_hdrv", 64'(txReqValid_out), 64'd0);
          if (txValid_out && txReady_in) begin
            chk("data_beat", txData_out, src_mem[src_idx % 256]);
            src_idx++;
            beats++;
            if (beats == NQ) begin
              mode = M_NONE;
              n_tlps++;
              tlp++;
              if (tlp == 4) begin
                tlp = 0;
                chunk++;
                set_f = 1'b1;
              end
            end
          end
        end
        default: begin
          chk("mtr_txv", 64'(txValid_out), 64'd1);
          chk("mtr_srdy", 64'(srcReady_out), 64'd0);
          if (txReady_in) begin
            chk("mtr_pay", txData_out, {32'(prev_c2f), 32'(chunk % 4)});
            last_mpay = txData_out;
            n_mbeats++;
            clr_f = 1'b1;
            mode = M_NONE;
          end
        end
      endcase
      owed_dec  = owed;
      owed      = set_f || (owed && !clr_f);
      prev_c2f  = c2f_rdptr;
      rdptr_dec = f2c_rdptr;
      en_dec    = dma_en;
      srcv_dec  = src_valid;
      busy_prev = busy_out;
    end
  endtask

  // Sample at the falling edge, drive just after the rising edge.
  task automatic step();
    @(negedge clk);
    monitor();
    @(posedge clk);
    #1;
    if (rnd_rdy) begin
      txReady_in    = ($urandom_range(0, 3) != 0);
      txReqReady_in = ($urandom_range(0, 3) != 0);
    end
    if (rnd_src) src_valid = ($urandom_range(0, 4) != 0);
    if (rnd_misc) begin
      if ($urandom_range(0, 49) == 0) c2f_rdptr = 2'($urandom);
      if ($urandom_range(0, 59) == 0) f2c_rdptr = 2'($urandom);
    end
    src_data = src_mem[src_idx % 256];
  endtask

  initial begin
    int d0, m0, t0, b;
    for (int i = 0; i < 256; i++) src_mem[i] = {$urandom, $urandom};
    reset_in = 1'b1; dma_en = 2'd0; f2c_base = '0; mtr_base = 29'd64;
    f2c_rdptr = 2'd0; c2f_rdptr = 2'd0; src_data = src_mem[0]; src_valid = 1'b0;
    txReqReady_in = 1'b1; txReady_in = 1'b1;
    step(); step();
    chk("rst_busy", 64'(busy_out), 64'd0);
    chk("rst_hdrv", 64'(txReqValid_out), 64'd0);
    chk("rst_txv", 64'(txValid_out), 64'd0);
    chk("rst_srdy", 64'(srcReady_out), 64'd0);
    chk("rst_wrptr", 64'(f2cWrPtr_out), 64'd0);
    chk("rst_txd", txData_out, 64'd0);

    // First chunk then its metrics writeback
    reset_in = 1'b0; dma_en = 2'd2; src_valid = 1'b1;
    for (int i = 0; i < 400 && n_mbeats < 1; i++) step();
    chk("t1_ndhdr", 64'(n_dhdr), 64'd4);
    for (int k = 0; k < 4; k++) chk("t1_addr", 64'(hdr_log[k]), 64'(k * 16));
    chk("t1_mpay", last_mpay, 64'h1);
    chk("t1_wrptr", 64'(f2cWrPtr_out), 64'd1);

    // Ring fills with rdptr=0, then one more chunk once released
    for (int i = 0; i < 800 && !(f2cWrPtr_out == 2'd3 && n_mbeats == 3); i++) step();
    repeat (40) step();
    chk("t2_ndhdr", 64'(n_dhdr), 64'd12);
    chk("t2_busy", 64'(busy_out), 64'd0);
    chk("t2_wrptr", 64'(f2cWrPtr_out), 64'd3);
    f2c_rdptr = 2'd1;
    for (int i = 0; i < 60 && n_dhdr < 13; i++) step();
    chk("t2_addr192", 64'(hdr_log[12]), 64'd192);
    for (int i = 0; i < 200 && !(f2cWrPtr_out == 2'd0 && n_mbeats == 4); i++) step();
    chk("t2_wrap", 64'(f2cWrPtr_out), 64'd0);
    chk("t2_nmtr", 64'(n_mbeats), 64'd4);

    // C2F pointer change mid-TLP under random ready toggling
    f2c_rdptr = 2'd3; rnd_rdy = 1'b1;
    for (int i = 0; i < 200 && !(mode == M_DATA && beats == 5); i++) step();
    c2f_rdptr = 2'd2; d0 = n_dhdr; m0 = n_mbeats;
    for (int i = 0; i < 400 && n_mbeats < m0 + 1; i++) step();
    chk("t3_mpay", last_mpay, {32'd2, 32'(chunk % 4)});
    chk("t3_order", 64'(n_dhdr), 64'(d0));
    rnd_rdy = 1'b0; txReady_in = 1'b1; txReqReady_in = 1'b1;

    // Source gap of 5 cycles mid-TLP
    for (int i = 0; i < 100 && !(mode == M_DATA && beats == 3); i++) step();
    src_valid = 1'b0; b = beats;
    for (int k = 0; k < 5; k++) begin
      step();
      chk("t4_txv", 64'(txValid_out), 64'd0);
    end
    chk("t4_beats", 64'(beats), 64'(b));
    src_valid = 1'b1;
    for (int i = 0; i < 40 && mode == M_DATA; i++) step();
    chk("t4_done", 64'(mode), 64'(M_NONE));

    // Stop at beat 7 lets the TLP finish
    for (int i = 0; i < 100 && !(mode == M_DATA && beats == 7); i++) step();
    dma_en = 2'd3; t0 = n_tlps; d0 = n_dhdr;
    for (int i = 0; i < 30 && mode == M_DATA; i++) step();
    chk("t5_finish", 64'(n_tlps), 64'(t0 + 1));
    repeat (20) step();
    chk("t5_idle", 64'(busy_out), 64'd0);
    chk("t5_nohdr", 64'(n_dhdr), 64'(d0));

    // Soft reset mid-TLP
    dma_en = 2'd2;
    for (int i = 0; i < 100 && !(mode == M_DATA && beats == 4); i++) step();
    dma_en = 2'd1;
    step();
    chk("t5_sr_busy", 64'(busy_out), 64'd0);
    chk("t5_sr_txv", 64'(txValid_out), 64'd0);
    chk("t5_sr_hdrv", 64'(txReqValid_out), 64'd0);
    chk("t5_sr_srdy", 64'(srcReady_out), 64'd0);
    chk("t5_sr_wrptr", 64'(f2cWrPtr_out), 64'd0);
    chk("t5_sr_txd", txData_out, 64'd0);
    f2c_base = 29'h1FFF_FFC0; mtr_base = 29'($urandom); dma_en = 2'd2; d0 = n_dhdr;
    for (int i = 0; i < 40 && n_dhdr == d0; i++) step();
    chk("t5_base", 64'(last_daddr), 64'(f2c_base));

    // Metrics header held by txReqReady low
    c2f_rdptr = 2'd1;
    for (int i = 0; i < 200 && !(txReqValid_out && txReqLen_out == 8'd1); i++) step();
    txReqReady_in = 1'b0;
    for (int k = 0; k < 10; k++) begin
      step();
      chk("t6_vld", 64'(txReqValid_out), 64'd1);
      chk("t6_addr", 64'(txReqAddr_out), 64'(mtr_base));
      chk("t6_srdy", 64'(srcReady_out), 64'd0);
    end
    txReqReady_in = 1'b1; m0 = n_mbeats;
    for (int i = 0; i < 10 && n_mbeats == m0; i++) step();
    chk("t6_c2f", 64'(last_mpay[63:32]), 64'd1);

    // Fully random traffic
    rnd_rdy = 1'b1; rnd_src = 1'b1; rnd_misc = 1'b1; b = src_idx;
    repeat (4000) step();
    chk("t7_progress", 64'(src_idx - b > 500), 64'd1);
    rnd_rdy = 1'b0; rnd_src = 1'b0; rnd_misc = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
